// File: rtl/gift_enc_param.sv
// gift_enc_param: parametrised GIFT-64 / GIFT-128 encryption core.
//
// The core holds a master key across blocks. Each plaintext is encrypted
// with ROUNDS_PER_CYCLE unrolled rounds per clock. outValid pulses for one
// cycle when outData is updated.
//
// Parameters:
//   BLOCK_BITS        64 (GIFT-64, 28 rounds) or 128 (GIFT-128, 40 rounds)
//   ROUNDS_PER_CYCLE  1, 2 or 4 rounds evaluated per clock
//
// Ports:
//   inClk        clock, rising edge
//   inRst        synchronous active-high reset
//   inKeyWr      load master key from inKeyData (accepted in IDLE only)
//   inKeyData    128-bit master key, k7..k0 = [127:112]..[15:0]
//   inDataWr     start encryption of inDataData (accepted in IDLE with a key)
//   inDataData   plaintext block
//   outData      last ciphertext, held until the next completion
//   outValid     one-cycle pulse when outData has just been updated
//   outBusy      encryption in progress
//   outKeyValid  a master key has been loaded since reset
module gift_enc_param #(
    parameter int BLOCK_BITS       = 128,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                  inClk,
    input  logic                  inRst,
    input  logic                  inKeyWr,
    input  logic [127:0]          inKeyData,
    input  logic                  inDataWr,
    input  logic [BLOCK_BITS-1:0] inDataData,
    output logic [BLOCK_BITS-1:0] outData,
    output logic                  outValid,
    output logic                  outBusy,
    output logic                  outKeyValid
);

    localparam int NR = (BLOCK_BITS == 64) ? 28 : 40;
    localparam int N  = NR / ROUNDS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!(BLOCK_BITS == 64 || BLOCK_BITS == 128)) begin : g_bad_block_bits
        $error("gift_enc_param: BLOCK_BITS must be 64 or 128");
    end
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
        $error("gift_enc_param: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic [5:0]            rc_r;
    logic [127:0]          master_key_r;
    logic [127:0]          key_r;
    logic [BLOCK_BITS-1:0] cipher_r;

    logic [BLOCK_BITS-1:0] next_cipher_s;
    logic [127:0]          next_key_s;
    logic [5:0]            next_rc_s;

    // GIFT 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;
            4'h1: y = 4'ha;
            4'h2: y = 4'h4;
            4'h3: y = 4'hc;
            4'h4: y = 4'h6;
            4'h5: y = 4'hf;
            4'h6: y = 4'h3;
            4'h7: y = 4'h9;
            4'h8: y = 4'h2;
            4'h9: y = 4'hd;
            4'ha: y = 4'hb;
            4'hb: y = 4'h7;
            4'hc: y = 4'h5;
            4'hd: y = 4'h0;
            4'he: y = 4'h8;
            4'hf: y = 4'he;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Destination of bit i under PermBits; the stride between bit groups
    // scales with the block width.
    function automatic int perm_pos(input int i);
        return 4 * (i / 16) + (BLOCK_BITS / 4) * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

    // One full round: SubCells, PermBits, AddRoundKey, AddConstant
    function automatic logic [BLOCK_BITS-1:0] round_f(
        input logic [BLOCK_BITS-1:0] s,
        input logic [127:0]          k,
        input logic [5:0]            c
    );
        logic [BLOCK_BITS-1:0] sub_v;
        logic [BLOCK_BITS-1:0] per_v;
        sub_v = '0;
        per_v = '0;
        for (int n = 0; n < BLOCK_BITS / 4; n++) begin
            sub_v[4*n +: 4] = sbox(s[4*n +: 4]);
        end
        for (int i = 0; i < BLOCK_BITS; i++) begin
            per_v[perm_pos(i)] = sub_v[i];
        end
        // GIFT-128 uses U=k5||k4 / V=k1||k0 on bits 2/1; GIFT-64 uses k1 / k0 on bits 1/0
        for (int i = 0; i < BLOCK_BITS / 4; i++) begin
            if (BLOCK_BITS == 128) begin
                per_v[4*i+2] = per_v[4*i+2] ^ k[64+i];
                per_v[4*i+1] = per_v[4*i+1] ^ k[i];
            end else begin
                per_v[4*i+1] = per_v[4*i+1] ^ k[16+i];
                per_v[4*i]   = per_v[4*i]   ^ k[i];
            end
        end
        per_v[23] = per_v[23] ^ c[5];
        per_v[19] = per_v[19] ^ c[4];
        per_v[15] = per_v[15] ^ c[3];
        per_v[11] = per_v[11] ^ c[2];
        per_v[7]  = per_v[7]  ^ c[1];
        per_v[3]  = per_v[3]  ^ c[0];
        per_v[BLOCK_BITS-1] = per_v[BLOCK_BITS-1] ^ 1'b1;
        return per_v;
    endfunction

    // k7..k0 <- k1>>>2, k0>>>12, k7, k6, k5, k4, k3, k2
    function automatic logic [127:0] key_upd(input logic [127:0] k);
        return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
    endfunction

    function automatic logic [5:0] rc_step(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    // Unrolled round chain; the constant is advanced before each round uses it
    always_comb begin
        logic [BLOCK_BITS-1:0] s_v;
        logic [127:0]          k_v;
        logic [5:0]            c_v;
        s_v = cipher_r;
        k_v = key_r;
        c_v = rc_r;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            c_v = rc_step(c_v);
            s_v = round_f(s_v, k_v, c_v);
            k_v = key_upd(k_v);
        end
        next_cipher_s = s_v;
        next_key_s    = k_v;
        next_rc_s     = c_v;
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            rc_r         <= 6'd0;
            master_key_r <= 128'd0;
            key_r        <= 128'd0;
            cipher_r     <= '0;
            outData      <= '0;
            outValid     <= 1'b0;
            outBusy      <= 1'b0;
            outKeyValid  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    outValid <= 1'b0;
                    if (inKeyWr) begin
                        master_key_r <= inKeyData;
                        outKeyValid  <= 1'b1;
                    end
                    // A key written on the same edge counts as loaded for this block
                    if (inDataWr && (outKeyValid || inKeyWr)) begin
                        cipher_r <= inDataData;
                        key_r    <= inKeyWr ? inKeyData : master_key_r;
                        rc_r     <= 6'd0;
                        cnt_r    <= '0;
                        outBusy  <= 1'b1;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cipher_r <= next_cipher_s;
                    key_r    <= next_key_s;
                    rc_r     <= next_rc_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        outData  <= next_cipher_s;
                        outValid <= 1'b1;
                        outBusy  <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    outValid <= 1'b0;
                    outBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gift_enc_param.sv
// tb_gift_enc_param: self-checking bench for gift_enc_param.
// Three instances cover GIFT-128 at 1 and 4 rounds/cycle and GIFT-64 at
// 2 rounds/cycle. Expected ciphertexts come from a bit-array model of GIFT
// that uses the published round-constant table.
module tb_gift_enc_param;

    localparam int NU = 3;
    localparam int UB [NU] = '{128, 128, 64};
    localparam int UN [NU] = '{40, 10, 14};
    localparam int SBOX [16] = '{1, 10, 4, 12, 6, 15, 3, 9, 2, 13, 11, 7, 5, 0, 8, 14};
    localparam logic [5:0] RC [40] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};
    localparam logic [127:0] KAT128 = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
    localparam logic [127:0] KAT64  = 128'h0000000000000000f62bc3ef34f775ac;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   key_wr;
    logic [2:0]   data_wr;
    logic [127:0] key_data;
    logic [127:0] data_in;
    logic [127:0] out0;
    logic [127:0] out1;
    logic [63:0]  out2;
    logic [2:0]   valid;
    logic [2:0]   busy;
    logic [2:0]   kval;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] cur_key [NU];

    always #5 clk = ~clk;

    gift_enc_param #(.BLOCK_BITS(128), .ROUNDS_PER_CYCLE(1)) u_g128_r1 (
        .inClk(clk), .inRst(rst), .inKeyWr(key_wr[0]), .inKeyData(key_data),
        .inDataWr(data_wr[0]), .inDataData(data_in), .outData(out0),
        .outValid(valid[0]), .outBusy(busy[0]), .outKeyValid(kval[0]));

    gift_enc_param #(.BLOCK_BITS(128), .ROUNDS_PER_CYCLE(4)) u_g128_r4 (
        .inClk(clk), .inRst(rst), .inKeyWr(key_wr[1]), .inKeyData(key_data),
        .inDataWr(data_wr[1]), .inDataData(data_in), .outData(out1),
        .outValid(valid[1]), .outBusy(busy[1]), .outKeyValid(kval[1]));

    gift_enc_param #(.BLOCK_BITS(64), .ROUNDS_PER_CYCLE(2)) u_g64_r2 (
        .inClk(clk), .inRst(rst), .inKeyWr(key_wr[2]), .inKeyData(key_data),
        .inDataWr(data_wr[2]), .inDataData(data_in[63:0]), .outData(out2),
        .outValid(valid[2]), .outBusy(busy[2]), .outKeyValid(kval[2]));

    // Reference GIFT encryption on an array of bits and an array of key words
    function automatic logic [127:0] ref_enc(input int bb, input logic [127:0] key,
                                             input logic [127:0] pt);
        logic [15:0]  kw [8];
        logic [15:0]  nk [8];
        bit           s [128];
        bit           t [128];
        logic [3:0]   nib;
        logic [3:0]   sv;
        logic [31:0]  uw;
        logic [31:0]  vw;
        logic [127:0] res;
        int           nr;
        int           p;
        nr = (bb == 64) ? 28 : 40;
        for (int i = 0; i < 8; i++) kw[i] = key[16*i +: 16];
        for (int i = 0; i < 128; i++) begin
            s[i] = (i < bb) ? pt[i] : 1'b0;
            t[i] = 1'b0;
        end
        for (int r = 0; r < nr; r++) begin
            for (int n = 0; n < bb / 4; n++) begin
                nib = {s[4*n+3], s[4*n+2], s[4*n+1], s[4*n]};
                sv = 4'(SBOX[nib]);
                for (int b = 0; b < 4; b++) t[4*n+b] = sv[b];
            end
            for (int i = 0; i < bb; i++) begin
                p = 4 * (i / 16) + (bb / 4) * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
                s[p] = t[i];
            end
            if (bb == 128) begin
                uw = {kw[5], kw[4]};
                vw = {kw[1], kw[0]};
                for (int i = 0; i < 32; i++) begin
                    s[4*i+2] = s[4*i+2] ^ uw[i];
                    s[4*i+1] = s[4*i+1] ^ vw[i];
                end
            end else begin
                for (int i = 0; i < 16; i++) begin
                    s[4*i+1] = s[4*i+1] ^ kw[1][i];
                    s[4*i]   = s[4*i]   ^ kw[0][i];
                end
            end
            for (int j = 0; j < 6; j++) s[4*j+3] = s[4*j+3] ^ RC[r][j];
            s[bb-1] = s[bb-1] ^ 1'b1;
            nk[7] = (kw[1] >> 2) | (kw[1] << 14);
            nk[6] = (kw[0] >> 12) | (kw[0] << 4);
            for (int i = 0; i < 6; i++) nk[i] = kw[i+2];
            kw = nk;
        end
        res = '0;
        for (int i = 0; i < bb; i++) res[i] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] get_out(input int u);
        case (u)
            0:       return out0;
            1:       return out1;
            default: return {64'd0, out2};
        endcase
    endfunction

    function automatic logic [127:0] rnd_blk(input int u);
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        if (UB[u] == 64) v[127:64] = 64'd0;
        return v;
    endfunction

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one block on unit u and wait for its completion; returns in the
    // outValid cycle. kpulse_at >= 0 writes key2 at that RUN cycle.
    task automatic run_block(input int u, input logic [127:0] pt, input logic [127:0] exp,
                             input bit with_key, input logic [127:0] key,
                             input int kpulse_at, input logic [127:0] key2, input string tag);
        int           lat;
        bit           stable;
        logic [127:0] prev;
        prev = get_out(u);
        data_in = pt;
        data_wr[u] = 1'b1;
        if (with_key) key_data = key;
        key_wr[u] = with_key;
        step();
        data_wr[u] = 1'b0;
        key_wr[u] = 1'b0;
        check($sformatf("%s_u%0d_busy", tag, u), 128'(busy[u]), 128'd1);
        lat = 0;
        stable = 1'b1;
        while (valid[u] !== 1'b1 && lat < 200) begin
            if (get_out(u) !== prev) stable = 1'b0;
            if (lat == kpulse_at) begin
                key_data = key2;
                key_wr[u] = 1'b1;
            end else begin
                key_wr[u] = 1'b0;
            end
            step();
            lat++;
        end
        key_wr[u] = 1'b0;
        check($sformatf("%s_u%0d_latency", tag, u), 128'(lat), 128'(UN[u]));
        check($sformatf("%s_u%0d_data", tag, u), get_out(u), exp);
        check($sformatf("%s_u%0d_hold", tag, u), 128'(stable), 128'd1);
        check($sformatf("%s_u%0d_busy_end", tag, u), 128'(busy[u]), 128'd0);
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] pt;
        logic [127:0] prev;
        logic [2:0]   seen;
        bit           wk;
        int           nrand;

        rst = 1'b1;
        key_wr = 3'b000;
        data_wr = 3'b000;
        key_data = 128'd0;
        data_in = 128'd0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        for (int u = 0; u < NU; u++) begin
            check($sformatf("rst_u%0d_data", u), get_out(u), 128'd0);
            check($sformatf("rst_u%0d_flags", u), {125'd0, valid[u], busy[u], kval[u]}, 128'd0);
        end

        // Data write without a key is ignored
        data_in = {$urandom, $urandom, $urandom, $urandom};
        data_wr = 3'b111;
        step();
        data_wr = 3'b000;
        seen = 3'b000;
        repeat (50) begin
            seen = seen | valid | busy;
            step();
        end
        for (int u = 0; u < NU; u++) begin
            check($sformatf("nokey_u%0d", u), {126'd0, seen[u], kval[u]}, 128'd0);
        end

        // Known answers with an all-zero key and plaintext
        for (int u = 0; u < NU; u++) begin
            key_data = 128'd0;
            key_wr[u] = 1'b1;
            step();
            key_wr[u] = 1'b0;
            cur_key[u] = 128'd0;
            check($sformatf("kat_u%0d_keyvalid", u), 128'(kval[u]), 128'd1);
            run_block(u, 128'd0, (UB[u] == 64) ? KAT64 : KAT128, 1'b0, 128'd0, -1, 128'd0, "kat");
            step();
            check($sformatf("kat_u%0d_pulse", u), 128'(valid[u]), 128'd0);
        end

        // Key and data on the same edge: block uses the new key
        for (int u = 0; u < NU; u++) begin
            k = rnd_key();
            pt = rnd_blk(u);
            run_block(u, pt, ref_enc(UB[u], k, pt), 1'b1, k, -1, 128'd0, "simul");
            cur_key[u] = k;
            step();
        end

        // Key retention, back-to-back blocks, key writes during RUN ignored
        for (int u = 0; u < NU; u++) begin
            k = rnd_key();
            key_data = k;
            key_wr[u] = 1'b1;
            step();
            key_wr[u] = 1'b0;
            cur_key[u] = k;
            for (int b = 0; b < 3; b++) begin
                pt = rnd_blk(u);
                run_block(u, pt, ref_enc(UB[u], k, pt), 1'b0, 128'd0, 3, ~k, "b2b");
            end
            prev = get_out(u);
            repeat (5) step();
            check($sformatf("idle_u%0d_hold", u), get_out(u), prev);
            check($sformatf("idle_u%0d_novalid", u), {127'd0, valid[u]}, 128'd0);
            pt = rnd_blk(u);
            run_block(u, pt, ref_enc(UB[u], k, pt), 1'b0, 128'd0, -1, 128'd0, "retain");
        end

        // Random key/plaintext pairs, mixing fresh keys and retained keys
        for (int u = 0; u < NU; u++) begin
            nrand = (UB[u] == 64) ? 200 : 25;
            for (int i = 0; i < nrand; i++) begin
                wk = 1'($urandom_range(0, 1));
                k = wk ? rnd_key() : cur_key[u];
                pt = rnd_blk(u);
                run_block(u, pt, ref_enc(UB[u], k, pt), wk, k, -1, 128'd0, "rand");
                cur_key[u] = k;
                repeat ($urandom_range(0, 2)) step();
            end
        end

        // Reset in the middle of a block, then recovery
        for (int u = 0; u < NU; u++) begin
            key_data = cur_key[u];
            key_wr[u] = 1'b1;
            step();
            key_wr[u] = 1'b0;
            data_in = rnd_blk(u);
            data_wr[u] = 1'b1;
            step();
            data_wr[u] = 1'b0;
            repeat (UN[u] / 2 - 1) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            check($sformatf("midrst_u%0d_data", u), get_out(u), 128'd0);
            check($sformatf("midrst_u%0d_flags", u), {125'd0, valid[u], busy[u], kval[u]}, 128'd0);
            seen = 3'b000;
            repeat (2 * UN[u]) begin
                seen[0] = seen[0] | valid[u] | busy[u];
                step();
            end
            check($sformatf("midrst_u%0d_quiet", u), {127'd0, seen[0]}, 128'd0);
            k = rnd_key();
            key_data = k;
            key_wr[u] = 1'b1;
            step();
            key_wr[u] = 1'b0;
            cur_key[u] = k;
            pt = rnd_blk(u);
            run_block(u, pt, ref_enc(UB[u], k, pt), 1'b0, 128'd0, -1, 128'd0, "recover");
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gift_enc_param.md
# gift_enc_param

Parametrised GIFT block-cipher encryption core and next-generation replacement for the fixed GIFT-128 encryptor. It supports GIFT-64 or GIFT-128 (selected by parameter) and 1, 2 or 4 unrolled rounds per clock. The master key is retained between blocks, so several plaintexts are encrypted under one key load. A completion strobe is added, and the core has a synchronous reset.

## Interface
Parameters:
- BLOCK_BITS, 128, cipher variant: 64 (GIFT-64, 28 rounds) or 128 (GIFT-128, 40 rounds); any other value is a synthesis-time error.
- ROUNDS_PER_CYCLE, 1, rounds per clock: 1, 2 or 4; any other value is a synthesis-time error.

Ports:
- inClk  in  1  clock; all logic on rising edge.
- inRst  in  1  synchronous active-high reset.
- inKeyWr  in  1  load master key from inKeyData.
- inKeyData  in  128  master key, k7..k0 = [127:112]..[15:0].
- inDataWr  in  1  start encryption of inDataData.
- inDataData  in  BLOCK_BITS  plaintext.
- outData  out  BLOCK_BITS  last ciphertext; held until next completion.
- outValid  out  1  one-cycle pulse: outData just updated.
- outBusy  out  1  encryption in progress.
- outKeyValid  out  1  a master key is loaded.

## Operation
- Single clock and synchronous active-high reset are fixed for this block.
- Derived values: NR = 28 (64-bit) or 40 (128-bit); N = NR / ROUNDS_PER_CYCLE cycles per block (64-bit: 28/14/7; 128-bit: 40/20/10).
- Registers:
  - master key, 128 bits
  - key state, 128 bits
  - cipher state, BLOCK_BITS
  - round-constant LFSR, 6 bits
  - cycle counter, ceil(log2(N+1)) bits
  - outData, outValid, outBusy, outKeyValid
- Round function, per standard GIFT, in this order: SubCells, PermBits, AddRoundKey, AddConstant.
  - AddRoundKey for GIFT-128: U = k5‖k4, V = k1‖k0; u_i is XORed into bit 4i+2, v_i into bit 4i+1.
  - AddRoundKey for GIFT-64: U = k1, V = k0; u_i is XORed into bit 4i+1, v_i into bit 4i.
  - AddConstant: c5..c0 are XORed into bits 23, 19, 15, 11, 7, 3. Bit BLOCK_BITS-1 is XORed with 1.
- Key update after each round: k7..k0 ← (k1>>>2), (k0>>>12), k7, k6, k5, k4, k3, k2.
- Constant update: (c5..c0) ← (c4, c3, c2, c1, c0, c5^c4^1). The LFSR starts at 0 and is updated before use, so round 1 uses 0x01.
- The round datapath is ROUNDS_PER_CYCLE chained copies of the round and key/constant update logic.
- FSM:
  - IDLE:
    - inKeyWr=1 loads the master key and sets outKeyValid.
    - inDataWr=1 with outKeyValid=1 loads the cipher state, copies the master key into the key state, clears the LFSR and counter, and moves to RUN.
    - inDataWr with outKeyValid=0 is ignored; there is no state change.
  - RUN: each cycle applies ROUNDS_PER_CYCLE rounds and increments the counter. On counter = N-1, write the result to outData, pulse outValid, and return to IDLE.
- Simultaneous inKeyWr and inDataWr in IDLE: the new key is stored and used for this block, and the data is accepted.
- inKeyWr and inDataWr during RUN are ignored; the master key and the in-flight block are unaffected.
- Reset, including mid-RUN:
  - outData = 0, outValid = 0, outBusy = 0, outKeyValid = 0
  - FSM to IDLE; counter, LFSR and key registers cleared
  - in-flight block discarded with no outValid.

## Timing
- Accept edge E0: inDataWr is sampled in IDLE. outBusy=1 from the cycle after E0.
- Edges E1..EN each perform ROUNDS_PER_CYCLE rounds.
- After EN: outData holds the ciphertext, outValid=1 for exactly one cycle, outBusy=0.
- Latency is N cycles from accept to outValid. Back-to-back throughput is one block per N+1 cycles: the next inDataWr can be sampled at E(N+1), the same cycle outValid is high.
- Key load takes effect at the sampling edge. outKeyValid rises the following cycle, but a same-edge inDataWr is still accepted.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- GIFT-128, ROUNDS_PER_CYCLE=1, key 0, plaintext 0 → outData 0xcd0bd738388ad3f668b15a36ceb6ff92 with outValid exactly 40 cycles after accept. Repeat with ROUNDS_PER_CYCLE=2 and 4: same value after 20 and 10 cycles.
- GIFT-64, key 0, plaintext 0 → 0xf62bc3ef34f775ac after 28, 14 or 7 cycles (per ROUNDS_PER_CYCLE). Then run 200 random key/plaintext pairs against the golden software model.
- Key retention: load the key once, then send 3 back-to-back plaintexts, each inDataWr in the outValid cycle → 3 correct ciphertexts spaced N+1 cycles apart; inKeyWr with a different key during RUN does not change any result.
- No key: inDataWr after reset with outKeyValid=0 → outBusy stays 0 and no outValid. Simultaneous key+data in IDLE → ciphertext uses the new key.
- Reset mid-RUN (cycle N/2) → the next cycle shows all outputs 0 and no outValid pulse afterwards. After reloading the key, a new block encrypts correctly.
- outData stability: outData keeps its value through idle cycles and during the next RUN, changing only on the outValid cycle.
